// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the ALU issue
// controller. Optional feature macro: ALU_OVF_TRAP_EN.
package alu_pkg;

  localparam int W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;

  localparam int FLAG_OVF  = 0;
  localparam int FLAG_LT   = 1;
  localparam int FLAG_ZERO = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_wb_decode.sv
// Writeback/error decode of one instruction word against the
// two-entry operand file. Purely combinational.
module alu_wb_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        wb_en,
  output logic        wb_idx,
  output logic        rd_rt_used,
  output logic        err
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  dst;
  logic        dst_ok;
  logic        imm_op;
  logic        rt_src;
  logic [10:0] lo_unused;

  assign op        = instr[31:26];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign lo_unused = instr[10:0];

  assign imm_op = (op == OP_ADDI)  | (op == OP_ADDIU) |
                  (op == OP_SLTI)  | (op == OP_SLTIU) |
                  (op == OP_ANDI)  | (op == OP_ORI)   |
                  (op == OP_XORI);

  assign rt_src = (op == OP_BEQ) | (op == OP_BNE) |
                  (op == OP_SW);

  always_comb begin
    dst        = 5'd0;
    dst_ok     = 1'b0;
    rd_rt_used = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dst        = rd;
        dst_ok     = 1'b1;
        rd_rt_used = 1'b1;
      end
      imm_op: begin
        dst    = rt;
        dst_ok = 1'b1;
      end
      rt_src: rd_rt_used = 1'b1;
      default: ;
    endcase
  end

  // lw and unknown opcodes fall through with no destination
  assign err    = (rs > 5'd1) | (rd_rt_used & (rt > 5'd1));
  assign wb_idx = dst[0];
  assign wb_en  = dst_ok & (dst <= 5'd1) & ~err;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential issue/writeback controller wrapped around the combinational
// ALU. ALU_OVF_TRAP_EN adds a sticky overflow trap that blocks writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int            W         = 32,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  input  logic         init_we,
  input  logic         init_sel,
  input  logic [W-1:0] init_data,
  output logic [31:0]  alu_instr,
  output logic [W-1:0] alu_regA,
  output logic [W-1:0] alu_regB,
  input  logic [W-1:0] alu_result,
  input  logic [2:0]   alu_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [2:0]   out_flags,
  output logic         out_wb,
`ifdef ALU_OVF_TRAP_EN
  output logic         trap,
`endif
  output logic         out_err
);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] reg0;
  logic [W-1:0] reg1;
  logic         dec_wb_en;
  logic         dec_wb_idx;
  logic         dec_err;
  logic         rt_used_unused;
  logic         wb_go;

  alu_wb_decode u_dec (
    .instr      (alu_instr),
    .wb_en      (dec_wb_en),
    .wb_idx     (dec_wb_idx),
    .rd_rt_used (rt_used_unused),
    .err        (dec_err)
  );

  assign alu_regA = reg0;
  assign alu_regB = reg1;

`ifdef ALU_OVF_TRAP_EN
  logic ovf_op;
  logic ovf_hit;

  assign ovf_op  = (alu_instr[31:26] == OP_ADDI) |
                   ((alu_instr[31:26] == OP_RTYPE) &
                    ((alu_instr[5:0] == FN_ADD) |
                     (alu_instr[5:0] == FN_SUB)));
  assign ovf_hit = ovf_op & alu_flags[FLAG_OVF] & ~dec_err;
  assign wb_go   = dec_wb_en & ~ovf_hit;

  always_ff @(posedge clk) begin
    if (reset)
      trap <= 1'b0;
    else if ((state_q == EXEC) && ovf_hit)
      trap <= 1'b1;
  end
`else
  assign wb_go = dec_wb_en;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Preload lands at the accept edge, so EXEC already sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg0       <= RESET_VAL;
      reg1       <= RESET_VAL;
      alu_instr  <= '0;
      out_result <= '0;
      out_flags  <= '0;
      out_wb     <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (init_we && !init_sel)
            reg0 <= init_data;
          if (init_we && init_sel)
            reg1 <= init_data;
          if (in_valid)
            alu_instr <= in_instr;
        end
        EXEC: begin
          out_result <= dec_err ? '0 : alu_result;
          out_flags  <= dec_err ? '0 : alu_flags;
          out_err    <= dec_err;
          out_wb     <= wb_go;
          if (wb_go && !dec_wb_idx)
            reg0 <= alu_result;
          if (wb_go && dec_wb_idx)
            reg1 <= alu_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl with a
// transaction-level model and a behavioural ALU.
module tb_alu_issue_ctrl;

`ifdef ALU_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        init_we;
  logic        init_sel;
  logic [31:0] init_data;
  logic [31:0] alu_instr;
  logic [31:0] alu_regA;
  logic [31:0] alu_regB;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_wb;
  logic        out_err;
`ifdef ALU_OVF_TRAP_EN
  logic        trap;
`endif

  alu_issue_ctrl #(.W(32), .RESET_VAL(32'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .init_we    (init_we),
    .init_sel   (init_sel),
    .init_data  (init_data),
    .alu_instr  (alu_instr),
    .alu_regA   (alu_regA),
    .alu_regB   (alu_regB),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_wb     (out_wb),
`ifdef ALU_OVF_TRAP_EN
    .trap       (trap),
`endif
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: {flags, result}
  function automatic logic [34:0] alu_f(input logic [31:0] ins,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] se;
    logic [31:0] ze;
    logic [31:0] r;
    logic        ovf;
    logic        lt;
    op  = ins[31:26];
    fn  = ins[5:0];
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'd0, ins[15:0]};
    r   = 32'd0;
    ovf = 1'b0;
    lt  = 1'b0;
    case (op)
      6'h00: case (fn)
        6'h20: begin
          r = a + b;
          ovf = (a[31] == b[31]) && (r[31] != a[31]);
        end
        6'h21: r = a + b;
        6'h22: begin
          r = a - b;
          ovf = (a[31] != b[31]) && (r[31] != a[31]);
        end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: begin lt = $signed(a) < $signed(b); r = {31'd0, lt}; end
        6'h2b: begin lt = a < b; r = {31'd0, lt}; end
        default: r = 32'd0;
      endcase
      6'h08: begin
        r = a + se;
        ovf = (a[31] == se[31]) && (r[31] != a[31]);
      end
      6'h09: r = a + se;
      6'h0a: begin lt = $signed(a) < $signed(se); r = {31'd0, lt}; end
      6'h0b: begin lt = a < se; r = {31'd0, lt}; end
      6'h0c: r = a & ze;
      6'h0d: r = a | ze;
      6'h0e: r = a ^ ze;
      6'h04, 6'h05: r = a - b;
      6'h23, 6'h2b: r = a + se;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), lt, ovf, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_f(alu_instr, alu_regA, alu_regB);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] res;
    logic [2:0]  fl;
    logic        wb;
    logic        err;
    logic        trp;
    logic [31:0] r0;
    logic [31:0] r1;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_r0 = 0;
  logic [31:0] m_r1 = 0;
  logic        m_trap = 0;
  int          last_acc;
  logic [31:0] l_res;
  logic [2:0]  l_fl;
  logic        l_wb;
  logic        l_err;

  task automatic model_exec(input logic [31:0] ins, output exp_t e);
    logic [34:0] o;
    int op, fn, rs, rt, rd, dest;
    bit reads_rt, err, ovf_op, hit, wb;
    op = int'(ins[31:26]); fn = int'(ins[5:0]);
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    o = alu_f(ins, m_r0, m_r1);
    dest = -1;
    if (op == 0) dest = rd;
    else if (op >= 8 && op <= 14) dest = rt;
    reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 'h2b);
    err = (rs > 1) || (reads_rt && rt > 1);
    ovf_op = (op == 0 && (fn == 'h20 || fn == 'h22)) || op == 8;
    hit = TRAP_EN && ovf_op && o[32] && !err;
    wb = !err && dest >= 0 && dest <= 1 && !hit;
    if (wb && dest == 0) m_r0 = o[31:0];
    if (wb && dest == 1) m_r1 = o[31:0];
    if (hit) m_trap = 1'b1;
    e.instr = ins;
    e.res = err ? 32'd0 : o[31:0];
    e.fl = err ? 3'd0 : o[34:32];
    e.wb = wb; e.err = err; e.trp = m_trap;
    e.r0 = m_r0; e.r1 = m_r1;
    e.acc = 0; e.seen = 0;
  endtask

  // Compare process: sampled 1 time unit after the falling edge
  initial begin
    forever begin
      @(negedge clk); #1;
      if (!reset && out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!q[0].seen) begin
            chk("latency", cyc, q[0].acc + 1);
            q[0].seen = 1;
          end
          chk("out_result", out_result, q[0].res);
          chk("out_flags", {29'd0, out_flags}, {29'd0, q[0].fl});
          chk("out_wb", {31'd0, out_wb}, {31'd0, q[0].wb});
          chk("out_err", {31'd0, out_err}, {31'd0, q[0].err});
          chk("regA", alu_regA, q[0].r0);
          chk("regB", alu_regB, q[0].r1);
          chk("alu_instr", alu_instr, q[0].instr);
          chk("in_ready_resp", {31'd0, in_ready}, 32'd0);
`ifdef ALU_OVF_TRAP_EN
          chk("trap", {31'd0, trap}, {31'd0, q[0].trp});
`endif
          if (out_ready) begin
            l_res = out_result; l_fl = out_flags;
            l_wb = out_wb; l_err = out_err;
            void'(q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    if (!in_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic preload(input logic sel, input logic [31:0] d);
    wait_idle();
    init_we = 1'b1; init_sel = sel; init_data = d;
    @(posedge clk); #1;
    init_we = 1'b0;
    if (sel) m_r1 = d; else m_r0 = d;
  endtask

  task automatic issue(input logic [31:0] ins, input bit iw,
                       input logic sel, input logic [31:0] d,
                       input int stall, input bit poke);
    exp_t e;
    int t;
    wait_idle();
    in_valid = 1'b1; in_instr = ins;
    init_we = iw; init_sel = sel; init_data = d;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; init_we = 1'b0;
    if (iw) begin if (sel) m_r1 = d; else m_r0 = d; end
    model_exec(ins, e);
    e.acc = cyc;
    last_acc = cyc;
    q.push_back(e);
    if (stall > 0) begin
      t = 0;
      while (!out_valid && t < 10) begin @(negedge clk); t++; end
      if (!out_valid) chk("resp_timeout", 32'd0, 32'd1);
      for (int i = 0; i < stall; i++) begin
        if (poke && i == 0) begin
          init_we = 1'b1; init_sel = 1'($urandom);
          init_data = $urandom;
        end
        @(negedge clk);
        init_we = 1'b0;
      end
      out_ready = 1'b1;
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic int rnd_idx();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(2, 31));
    return int'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h7fffffff;
      1: return 32'h80000000;
      2: return 32'hffffffff;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    int ops[13] = '{0, 8, 9, 10, 11, 12, 13, 14, 4, 5, 'h23, 'h2b, 'h3f};
    int fns[11] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                    'h2a, 'h2b, 'h08};
    int op;
    op = ops[$urandom_range(0, 12)];
    if (op == 0)
      return rtype(rnd_idx(), rnd_idx(), rnd_idx(),
                   fns[$urandom_range(0, 10)]);
    return itype(op, rnd_idx(), rnd_idx(), int'($urandom_range(0, 65535)));
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int accs[5];
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'd0;
    init_we = 1'b0; init_sel = 1'b0; init_data = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_instr", alu_instr, 32'd0);
    chk("rst_regA", alu_regA, 32'd0);
    chk("rst_regB", alu_regB, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_misc", {27'd0, out_flags, out_wb, out_err}, 32'd0);
`ifdef ALU_OVF_TRAP_EN
    chk("rst_trap", {31'd0, trap}, 32'd0);
`endif

    // 1: add rd=0 with reg1 preloaded in the accept cycle
    preload(1'b0, 32'd5);
    issue(32'h00010020, 1'b1, 1'b1, 32'd7, 0, 0);
    wait_idle();
    chk("t1_result", l_res, 32'd12);
    chk("t1_flags", {29'd0, l_fl}, 32'd0);
    chk("t1_wb", {31'd0, l_wb}, 32'd1);
    chk("t1_reg0", alu_regA, 32'd12);

    // 2: signed overflow on add rd=1
    preload(1'b0, 32'h7fffffff);
    preload(1'b1, 32'd1);
    issue(rtype(0, 1, 1, 'h20), 0, 0, 0, 0, 0);
    wait_idle();
    chk("t2_ovf", {31'd0, l_fl[0]}, 32'd1);
`ifdef ALU_OVF_TRAP_EN
    chk("t2_reg1", alu_regB, 32'd1);
    chk("t2_trap", {31'd0, trap}, 32'd1);
`else
    chk("t2_reg1", alu_regB, 32'h80000000);
`endif

    // 3: beq equal operands
    preload(1'b0, 32'd9);
    preload(1'b1, 32'd9);
    issue(itype(4, 0, 1, 0), 0, 0, 0, 0, 0);
    wait_idle();
    chk("t3_flags", {29'd0, l_fl}, 32'd4);
    chk("t3_wb", {31'd0, l_wb}, 32'd0);
    chk("t3_regs", alu_regA ^ alu_regB ^ 32'd9, 32'd9);

    // 4: slti / sltiu with reg0 = -3, imm = 2
    preload(1'b0, 32'hfffffffd);
    issue(itype(10, 0, 1, 2), 0, 0, 0, 0, 0);
    wait_idle();
    chk("t4_slti_reg1", alu_regB, 32'd1);
    chk("t4_slti_lt", {31'd0, l_fl[1]}, 32'd1);
    issue(itype(11, 0, 1, 2), 0, 0, 0, 0, 0);
    wait_idle();
    chk("t4_sltiu_reg1", alu_regB, 32'd0);

    // 5: rs = 3 error, held 4 cycles with an ignored preload
    issue(rtype(3, 1, 0, 'h20), 0, 0, 0, 4, 1);
    wait_idle();
    chk("t5_err", {31'd0, l_err}, 32'd1);
    chk("t5_wb", {31'd0, l_wb}, 32'd0);
    chk("t5_result", l_res, 32'd0);

    // 6: reset during EXEC discards the instruction
    preload(1'b0, 32'd21);
    preload(1'b1, 32'd4);
    wait_idle();
    in_valid = 1'b1; in_instr = 32'h00010020;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_r0 = 32'd0; m_r1 = 32'd0; m_trap = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("t6_reg0", alu_regA, 32'd0);

    // back-to-back stream, out_ready high
    preload(1'b0, 32'd3);
    for (int i = 0; i < 5; i++) begin
      issue(rtype(0, 1, i % 2, 'h21), 0, 0, 0, 0, 0);
      accs[i] = last_acc;
    end
    for (int i = 1; i < 5; i++)
      chk("t6_spacing", accs[i] - accs[i-1], 32'd3);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      issue(rnd_instr(), ($urandom_range(0, 3) == 0), 1'($urandom),
            rnd_val(), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 40) == 0) begin
        wait_idle();
        q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_r0 = 32'd0; m_r1 = 32'd0; m_trap = 1'b0;
      end
    end
    wait_idle();
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
